// File: rtl/em_pipe_stage.sv
// em_pipe_stage
// EX->MEM pipeline register for the 5-stage MIPS core.
// It holds the instruction, PC, ALU result, store data, destination register and a sideband bus.
// It supports a valid bit, stall (hold), flush (bubble insert) and a consecutive-stall watchdog.
// Every output comes from a register, or from pc_q alone in the case of pc4_o/pc8_o.
module em_pipe_stage #(
    parameter int                 DATA_W    = 32,
    parameter int                 SB_W      = 8,
    parameter logic [DATA_W-1:0]  PC_RESET  = DATA_W'(32'h3000),
    parameter logic [DATA_W-1:0]  NOP_IR    = DATA_W'(32'h0),
    parameter int                 CNT_W     = 8,
    parameter int                 STALL_MAX = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] ir_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] ao_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic [4:0]        wa_i,
    input  logic [SB_W-1:0]   sb_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] ir_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic [DATA_W-1:0] pc8_o,
    output logic [DATA_W-1:0] ao_o,
    output logic [DATA_W-1:0] rt_o,
    output logic [4:0]        wa_o,
    output logic [SB_W-1:0]   sb_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              stall_timeout_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        TIMEOUT  = 2'd2
    } stall_state_e;

    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   STALL_HIT = (CNT_W+1)'(STALL_MAX);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] ir_q,    ir_d;
    logic [DATA_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] ao_q,    ao_d;
    logic [DATA_W-1:0] rt_q,    rt_d;
    logic [4:0]        wa_q,    wa_d;
    logic [SB_W-1:0]   sb_q,    sb_d;

    stall_state_e      state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              timeout_q;

    logic              stalling;
    logic              bubble;
    logic [CNT_W:0]    cnt_plus1;

    // A stall edge is one where stall_i is high and no flush overrides it.
    // A bubble is written either on a flush or on a load of an invalid instruction.
    assign stalling  = stall_i & ~flush_i;
    assign bubble    = flush_i | (~stall_i & ~valid_i);
    assign cnt_plus1 = {1'b0, cnt_q} + (CNT_W+1)'(1);

    // Next-state selection for the data fields: flush > stall > load.
    always_comb begin
        valid_d = valid_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        ao_d    = ao_q;
        rt_d    = rt_q;
        wa_d    = wa_q;
        sb_d    = sb_q;
        if (bubble) begin
            valid_d = 1'b0;
            ir_d    = NOP_IR;
            pc_d    = PC_RESET;
            ao_d    = '0;
            rt_d    = '0;
            wa_d    = '0;
            sb_d    = '0;
        end else if (!stall_i) begin
            valid_d = 1'b1;
            ir_d    = ir_i;
            pc_d    = pc_i;
            ao_d    = ao_i;
            rt_d    = rt_i;
            wa_d    = wa_i;
            sb_d    = sb_i;
        end
    end

    // Stage data registers, cleared to a bubble on asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ir_q    <= NOP_IR;
            pc_q    <= PC_RESET;
            ao_q    <= '0;
            rt_q    <= '0;
            wa_q    <= '0;
            sb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            ao_q    <= ao_d;
            rt_q    <= rt_d;
            wa_q    <= wa_d;
            sb_q    <= sb_d;
        end
    end

    // Stall watchdog FSM: a saturating consecutive-stall count plus a sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (stalling) begin
                if (cnt_q != CNT_SAT) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (cnt_plus1 == STALL_HIT) begin
                    timeout_q <= 1'b1;
                    state_q   <= TIMEOUT;
                end else if (state_q != TIMEOUT) begin
                    state_q <= COUNTING;
                end
            end else begin
                cnt_q <= '0;
                if (state_q != TIMEOUT) begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign valid_o         = valid_q;
    assign ir_o            = ir_q;
    assign pc_o            = pc_q;
    assign pc4_o           = pc_q + DATA_W'(4);
    assign pc8_o           = pc_q + DATA_W'(8);
    assign ao_o            = ao_q;
    assign rt_o            = rt_q;
    assign wa_o            = valid_q ? wa_q : 5'd0;
    assign sb_o            = sb_q;
    assign stall_cnt_o     = cnt_q;
    assign stall_timeout_o = timeout_q;

endmodule
